axi_master_rd: RTL

//  AXI4 read-channel master (AR + R) that pairs with the DDR3/AXI read slave.
//  It accepts a single-burst read request from the user side and issues one INCR burst on AR.
//  It collects the R beats and streams them to a user write port, normally a read-data FIFO.
//  It checks burst integrity (RLAST position, RRESP) and reports completion and error.

---
 rtl/axi_master_rd.sv | 105 ++++++++++
 1 files changed

// File: rtl/axi_master_rd.sv
// AXI4 read master: issues one INCR burst on AR per accepted request and streams the
// R beats straight to a user sink, flagging RRESP and RLAST-position errors.
module axi_master_rd #(
    parameter int         DATA_WIDTH = 64,
    parameter int         ADDR_WIDTH = 30,
    parameter logic [3:0] AXI_ID     = 4'b0000,
    parameter logic [2:0] AXI_SIZE   = 3'b011
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_start,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [7:0]            rd_len,
    output logic                  rd_busy,
    output logic                  rd_done,
    output logic                  rd_err,
    input  logic                  rd_fifo_ready,
    output logic                  rd_fifo_wr_en,
    output logic [DATA_WIDTH-1:0] rd_fifo_data,
    output logic [3:0]            m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [1:0] {IDLE = 2'd0, RA = 2'd1, RD = 2'd2} state_t;

    state_t     state;
    logic [7:0] beat_cnt;
    logic       r_hs;
    logic       beat_bad;

    assign m_axi_arid    = AXI_ID;
    assign m_axi_arsize  = AXI_SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0010;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;

    // Ready is combinational on the sink so a beat is only taken when it can be stored.
    assign m_axi_rready  = (state == RD) & rd_fifo_ready;
    assign r_hs          = m_axi_rvalid & m_axi_rready;
    assign rd_fifo_wr_en = r_hs;
    assign rd_fifo_data  = m_axi_rdata;
    assign rd_busy       = (state != IDLE);

    assign beat_bad = (m_axi_rresp != 2'b00) ||
                      ( m_axi_rlast && (beat_cnt != m_axi_arlen)) ||
                      (!m_axi_rlast && (beat_cnt == m_axi_arlen));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            rd_done       <= 1'b0;
            rd_err        <= 1'b0;
            beat_cnt      <= '0;
        end else begin
            rd_done <= 1'b0;
            case (state)
                IDLE: if (rd_start) begin
                    state         <= RA;
                    m_axi_araddr  <= rd_addr;
                    m_axi_arlen   <= rd_len;
                    m_axi_arvalid <= 1'b1;
                    rd_err        <= 1'b0;
                    beat_cnt      <= '0;
                end
                RA: if (m_axi_arvalid && m_axi_arready) begin
                    m_axi_arvalid <= 1'b0;
                    state         <= RD;
                end
                RD: if (r_hs) begin
                    if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
                    if (beat_bad) rd_err <= 1'b1;
                    // Only rlast ends the burst; surplus beats keep flowing and stay flagged.
                    if (m_axi_rlast) begin
                        state   <= IDLE;
                        rd_done <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    m_axi_arvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule
